// File: rtl/hamming_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | hamming_pkg : extended Hamming (SEC-DED) encode/decode helpers   Rev 1.0   |
// +---------------------------------------------------------------------------+
package hamming_pkg;

  localparam int MAX_DATA = 32;
  localparam int MAX_CODE = 64;

  typedef logic [MAX_DATA-1:0] data_t;
  typedef logic [MAX_CODE-1:0] code_t;

  typedef struct packed {
    data_t      data;
    logic       corrected;
    logic       uncorrectable;
    logic [5:0] syndrome;
  } dec_t;

  function automatic int par_width(input int data_width);
    int p = 1;
    while ((1 << p) < data_width + p + 1) p++;
    return p;
  endfunction

  // Data bits fill non-power-of-two positions LSB first; bit 0 is overall parity.
  function automatic code_t encode(input data_t data, input int dw, input int pw);
    code_t      code = '0;
    logic [5:0] syn  = '0;
    logic [5:0] pp;
    int         d    = 0;
    for (int pos = 1; pos < MAX_CODE; pos++) begin
      if (pos <= dw + pw && (pos & (pos - 1)) != 0) begin
        code[pos[5:0]] = data[d[4:0]];
        if (data[d[4:0]]) syn ^= pos[5:0];
        d++;
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (i < pw) begin
        pp       = 6'(1 << i);
        code[pp] = syn[i];
      end
    end
    code[0] = ^code;
    return code;
  endfunction

  function automatic dec_t decode(input code_t code, input int dw, input int pw);
    dec_t       r;
    code_t      fixed;
    logic [5:0] syn = '0;
    logic       p;
    int         n   = dw + pw;
    int         d   = 0;
    for (int pos = 1; pos < MAX_CODE; pos++) begin
      if (pos <= n && code[pos[5:0]]) syn ^= pos[5:0];
    end
    p                = ^code;
    fixed            = code;
    r.corrected      = 1'b0;
    r.uncorrectable  = 1'b0;
    if (syn != '0 && p) begin
      if (int'(syn) <= n) begin
        fixed[syn]  = ~fixed[syn];
        r.corrected = 1'b1;
      end else begin
        r.uncorrectable = 1'b1;
      end
    end else if (p) begin
      r.corrected = 1'b1;
    end else if (syn != '0) begin
      r.uncorrectable = 1'b1;
    end
    r.data = '0;
    for (int pos = 1; pos < MAX_CODE; pos++) begin
      if (pos <= n && (pos & (pos - 1)) != 0) begin
        r.data[d[4:0]] = fixed[pos[5:0]];
        d++;
      end
    end
    r.syndrome = syn;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_channel_sync_fifo.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | sync_fifo : register-array FIFO with combinational head read     Rev 1.0   |
// +---------------------------------------------------------------------------+
module sync_fifo #(
  parameter  int WIDTH = 13,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_level == (AW+1)'(DEPTH));
  assign empty   = (r_level == '0);
  assign level   = r_level;
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/hamming_channel.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | hamming_channel : SEC-DED encode, FIFO, inject, decode, counters Rev 1.0   |
// +---------------------------------------------------------------------------+
module hamming_channel
  import hamming_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  parameter  int CNT_WIDTH  = 16,
  localparam int PAR_WIDTH  = par_width(DATA_WIDTH),
  localparam int CODE_WIDTH = DATA_WIDTH + PAR_WIDTH + 1,
  localparam int LVL_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  inj_en,
  input  logic [CODE_WIDTH-1:0] inj_mask,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_corrected,
  output logic                  m_uncorrectable,
  output logic [CNT_WIDTH-1:0]  corr_count,
  output logic [CNT_WIDTH-1:0]  uncorr_count,
  input  logic                  clr_counts,
  output logic [LVL_WIDTH-1:0]  level
);

  logic [CODE_WIDTH-1:0] w_code;
  logic [CODE_WIDTH-1:0] w_head;
  logic [CODE_WIDTH-1:0] w_raw;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  dec_t                  w_dec;
  logic                  r_up;

  // r_up holds s_ready low until the first edge after reset release.
  assign s_ready = r_up && !w_full;
  assign w_push  = s_valid && s_ready;
  assign w_pop   = !w_empty && (!m_valid || m_ready);
  assign w_code  = CODE_WIDTH'(encode(data_t'(s_data), DATA_WIDTH, PAR_WIDTH));
  assign w_raw   = w_head ^ (inj_en ? inj_mask : '0);
  assign w_dec   = decode(code_t'(w_raw), DATA_WIDTH, PAR_WIDTH);

  sync_fifo #(
    .WIDTH (CODE_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_push),
    .wr_data (w_code),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (level)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_up            <= 1'b0;
      m_valid         <= 1'b0;
      m_data          <= '0;
      m_corrected     <= 1'b0;
      m_uncorrectable <= 1'b0;
    end else begin
      r_up <= 1'b1;
      if (w_pop) begin
        m_valid         <= 1'b1;
        m_data          <= DATA_WIDTH'(w_dec.data);
        m_corrected     <= w_dec.corrected;
        m_uncorrectable <= w_dec.uncorrectable;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else if (clr_counts) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else if (w_pop) begin
      if (w_dec.corrected && corr_count != '1)
        corr_count <= corr_count + CNT_WIDTH'(1);
      if (w_dec.uncorrectable && uncorr_count != '1)
        uncorr_count <= uncorr_count + CNT_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hamming_channel.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_hamming_channel : scoreboard bench for hamming_channel        Rev 1.0   |
// +---------------------------------------------------------------------------+
module tb_hamming_channel;

  localparam int DW  = 8;
  localparam int CW  = 13;
  localparam int CNT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          inj_en = 1'b0;
  logic [CW-1:0] inj_mask = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_corrected;
  logic          m_uncorrectable;
  logic [CNT-1:0] corr_count;
  logic [CNT-1:0] uncorr_count;
  logic          clr_counts = 1'b0;
  logic [4:0]    level;

  typedef struct {
    logic [DW-1:0] d;
    logic          c;
    logic          u;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  hamming_channel #(
    .DATA_WIDTH (DW),
    .DEPTH      (16),
    .CNT_WIDTH  (CNT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_data          (s_data),
    .inj_en          (inj_en),
    .inj_mask        (inj_mask),
    .m_valid         (m_valid),
    .m_ready         (m_ready),
    .m_data          (m_data),
    .m_corrected     (m_corrected),
    .m_uncorrectable (m_uncorrectable),
    .corr_count      (corr_count),
    .uncorr_count    (uncorr_count),
    .clr_counts      (clr_counts),
    .level           (level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every word handed over (m_valid & m_ready) is matched against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_valid && m_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%0h expected none", m_data);
        end else begin
          e = q.pop_front();
          check("m_data", 32'(m_data), 32'(e.d));
          check("m_corrected", 32'(m_corrected), 32'(e.c));
          check("m_uncorrectable", 32'(m_uncorrectable), 32'(e.u));
        end
      end
    end
  end

  task automatic push(input logic [DW-1:0] d, input logic [DW-1:0] ed,
                      input logic c, input logic u);
    int n = 0;
    while (!s_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_ready) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got s_ready=0 expected 1");
      return;
    end
    s_valid = 1'b1;
    s_data  = d;
    q.push_back('{ed, c, u});
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  // Single word with the mask held over the push edge and the following pop edge.
  task automatic inj_push(input logic [DW-1:0] d, input logic [CW-1:0] mask,
                          input logic [DW-1:0] ed, input logic c, input logic u);
    inj_en   = 1'b1;
    inj_mask = mask;
    push(d, ed, c, u);
    @(posedge clk); #1;
    inj_en   = 1'b0;
    inj_mask = '0;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while ((q.size() != 0 || level != 0) && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_queue", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_corr", 32'(corr_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("s_ready_after_rst", 32'(s_ready), 32'd1);
    m_ready = 1'b1;

    // Latency: accepted at edge N, valid from edge N+1.
    s_valid = 1'b1;
    s_data  = 8'hA5;
    q.push_back('{8'hA5, 1'b0, 1'b0});
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    check("lat_not_yet", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(m_valid), 32'd1);
    @(posedge clk); #1;
    check("clean_corr", 32'(corr_count), 32'd0);
    check("clean_uncorr", 32'(uncorr_count), 32'd0);

    inj_push(8'hA5, 13'h0008, 8'hA5, 1'b1, 1'b0);
    check("corr_1", 32'(corr_count), 32'd1);
    inj_push(8'hA5, 13'h0001, 8'hA5, 1'b1, 1'b0);
    check("corr_2", 32'(corr_count), 32'd2);
    inj_push(8'hA5, 13'h0006, 8'hA5, 1'b0, 1'b1);
    check("uncorr_1", 32'(uncorr_count), 32'd1);
    // Positions 2,3: syndrome 1 with even parity; raw d0 flipped.
    inj_push(8'hA5, 13'h000C, 8'hA4, 1'b0, 1'b1);
    check("uncorr_2", 32'(uncorr_count), 32'd2);
    // Positions 1,4,8: syndrome 13 is beyond position 12.
    inj_push(8'hA5, 13'h0112, 8'hA5, 1'b0, 1'b1);
    check("uncorr_3", 32'(uncorr_count), 32'd3);
    inj_push(8'h5A, 13'h0006, 8'h5A, 1'b0, 1'b1);
    check("uncorr_sat", 32'(uncorr_count), 32'd3);
    check("corr_hold", 32'(corr_count), 32'd2);

    clr_counts = 1'b1;
    @(posedge clk); #1;
    clr_counts = 1'b0;
    check("clr_corr", 32'(corr_count), 32'd0);
    check("clr_uncorr", 32'(uncorr_count), 32'd0);

    inj_push(8'h3C, 13'h0010, 8'h3C, 1'b1, 1'b0);
    inj_push(8'h81, 13'h1000, 8'h81, 1'b1, 1'b0);
    inj_push(8'h00, 13'h0200, 8'h00, 1'b1, 1'b0);
    inj_push(8'hFF, 13'h0004, 8'hFF, 1'b1, 1'b0);
    inj_push(8'h69, 13'h0040, 8'h69, 1'b1, 1'b0);
    check("corr_sat", 32'(corr_count), 32'd3);

    // Clear coincides with the pop of a sixth corrected word.
    inj_en   = 1'b1;
    inj_mask = 13'h0800;
    push(8'hC3, 8'hC3, 1'b1, 1'b0);
    clr_counts = 1'b1;
    @(posedge clk); #1;
    clr_counts = 1'b0;
    inj_en     = 1'b0;
    inj_mask   = '0;
    check("clr_wins", 32'(corr_count), 32'd0);
    repeat (2) begin @(posedge clk); #1; end

    // Fill: one word in the output register, sixteen in the FIFO.
    m_ready = 1'b0;
    for (int i = 0; i <= 16; i++) push(8'(i), 8'(i), 1'b0, 1'b0);
    check("full_s_ready", 32'(s_ready), 32'd0);
    check("full_level", 32'(level), 32'd16);
    check("full_m_valid", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    wait_drain(60);
    check("drain_level", 32'(level), 32'd0);

    // Mid-stream reset with level 5 and a word held in the output register.
    m_ready  = 1'b0;
    inj_en   = 1'b1;
    inj_mask = 13'h0001;
    push(8'h11, 8'h11, 1'b1, 1'b0);
    @(posedge clk); #1;
    inj_en   = 1'b0;
    inj_mask = '0;
    for (int i = 0; i < 5; i++) push(8'(8'h12 + i), 8'(8'h12 + i), 1'b0, 1'b0);
    check("pre_rst_level", 32'(level), 32'd5);
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    check("pre_rst_corr", 32'(corr_count), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    check("arst_m_valid", 32'(m_valid), 32'd0);
    check("arst_m_data", 32'(m_data), 32'd0);
    check("arst_flags", 32'({m_corrected, m_uncorrectable}), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_s_ready", 32'(s_ready), 32'd0);
    check("arst_counts", 32'({corr_count, uncorr_count}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_s_ready", 32'(s_ready), 32'd1);
    m_ready = 1'b1;
    push(8'h3C, 8'h3C, 1'b0, 1'b0);
    wait_drain(20);
    repeat (6) begin @(posedge clk); #1; end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hamming_channel.md
# hamming_channel

Parametrised SEC-DED Hamming link stage, the successor to the fixed 8-to-12 encoder/decoder pair between the UART receiver and transmitter. It accepts data words on a valid/ready stream, encodes them with an extended Hamming code and buffers the codewords in a FIFO of configurable depth. On the way out it applies optional error injection, then decodes with single-error correction and double-error detection. It exposes per-word error flags and saturating error counters for link diagnostics.

## Interface
- DATA_WIDTH, 8, payload bits per word (2..32)
- DEPTH, 16, FIFO depth in codewords; power of two, >= 2
- CNT_WIDTH, 16, width of each error counter
- Derived: PAR_WIDTH = smallest p with 2^p >= DATA_WIDTH+p+1 (4 for 8 bits); CODE_WIDTH = DATA_WIDTH+PAR_WIDTH+1 (13 for 8 bits)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- s_valid  in  1  ingress word valid
- s_ready  out  1  ingress can accept
- s_data  in  DATA_WIDTH  ingress payload
- inj_en  in  1  apply inj_mask to the codeword popped this cycle
- inj_mask  in  CODE_WIDTH  XOR mask on the codeword (bit 0 = overall parity)
- m_valid  out  1  egress word valid
- m_ready  in  1  egress consumer ready
- m_data  out  DATA_WIDTH  decoded (corrected) payload
- m_corrected  out  1  word had a single-bit error, now corrected
- m_uncorrectable  out  1  double error detected; m_data is the raw extracted data
- corr_count  out  CNT_WIDTH  count of corrected words, saturating
- uncorr_count  out  CNT_WIDTH  count of uncorrectable words, saturating
- clr_counts  in  1  synchronous clear of both counters
- level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Codeword layout: bit 0 is overall even parity over bits 1..CODE_WIDTH-1. Positions 1..DATA_WIDTH+PAR_WIDTH are standard Hamming positions. Parity bits sit at powers of two. Data bits fill the remaining positions, LSB first, in ascending order.
- Ingress: a transfer occurs when s_valid & s_ready. The word is encoded combinationally and written into the FIFO at that edge. s_ready = !full; there is no write-through when full, even if a pop happens in the same cycle.
- Pop: when the FIFO is not empty and (m_valid == 0 or m_ready == 1), the head codeword is read and XORed with inj_mask if inj_en is set. It is then decoded and loaded into the output register.
- Decode: the syndrome S is the XOR of the indices of the set bits. P is the recomputed overall parity (1 = mismatch).
  - S == 0, P == 0: clean; both flags 0.
  - S != 0, P == 1, S <= DATA_WIDTH+PAR_WIDTH: flip bit S; m_corrected = 1.
  - S == 0, P == 1: error in bit 0; data untouched; m_corrected = 1.
  - S != 0, P == 0, or S out of range: m_uncorrectable = 1; raw data is passed.
- Counters increment on the output-register load of a flagged word and saturate at all-ones. When clr_counts coincides with an increment, clr_counts wins.
- Simultaneous push and pop while not full: level is unchanged and both operations complete. Pointers wrap modulo DEPTH.

## Timing
- Latency: a word accepted at edge N is loaded at edge N+1 and presented with m_valid high from edge N+1 (second cycle after s_valid is sampled), provided the output register is free.
- Throughput is one word per cycle when m_ready is held high.
- m_data and flags hold stable while m_valid & !m_ready.
- Reset (asynchronous, any time, including mid-stream):
  - FIFO is emptied and level = 0.
  - m_valid, m_data, m_corrected, m_uncorrectable and both counters go to 0.
  - s_ready is 0 while rst is high and 1 from the first edge after release.
  - In-flight words are discarded.

## Structure
- Package hamming_pkg:
  - function par_width(data_width)
  - functions encode and decode, parametrised by the width arguments
  - decode result struct: data, corrected, uncorrectable, syndrome
- Sub-module sync_fifo: DEPTH x CODE_WIDTH register array with combinational head read, full/empty/level outputs and asynchronous active-high reset.
- The top level holds the encoder, the pop/output-register control and the counters.

## Test plan
- DATA_WIDTH=8: push 0xA5 with inj_en=0 and m_ready=1 -> m_valid high from the second cycle after acceptance, m_data=0xA5, both flags 0, counters 0.
- Push 0xA5 with inj_mask=13'h0008 at the pop -> m_data=0xA5, m_corrected=1, corr_count=1. Repeat with inj_mask=13'h0001 -> corrected, corr_count=2.
- inj_mask=13'h0006 (two bits) -> m_uncorrectable=1, m_corrected=0, uncorr_count=1.
- With m_ready=0, push 0x00..0x10 -> after 16 FIFO writes plus 1 in the output register, s_ready=0 and level=16. Then raise m_ready -> 17 words egress in order, level returns to 0.
- CNT_WIDTH=2: inject 5 single errors -> corr_count=3. Then pulse clr_counts together with a sixth single error -> corr_count=0.
- Assert rst while level=5 and m_valid=1 -> all outputs 0 immediately. After release, s_ready=1 and the next push of 0x3C egresses as 0x3C only.
